ex_mem_pipe: RTL

Parametrised EX→MEM pipeline stage register with valid/ready flow control, synchronous flush, an optional skid buffer and a saturating back-pressure counter. It carries the GPR write-back bundle (wdata, wd, wreg) and the HI/LO write bundle (whilo, hi, lo) from the execute stage to the memory-access stage. It supports stalls and exceptions without dropping or duplicating instructions.

---
 rtl/ex_mem_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe
//
// EX -> MEM pipeline stage register with valid/ready handshaking. Carries
// the GPR write-back bundle (wdata, wd, wreg) and the HI/LO write bundle
// (whilo, hi, lo). Supports stalls, a synchronous flush, an optional
// two-entry skid buffer and a saturating back-pressure counter.
//
// Parameters
//   DATA_W : width of wdata / hi / lo
//   ADDR_W : width of the GPR destination address
//   SKID   : 1 = main + skid entry with registered ex_ready,
//            0 = single entry with combinational ex_ready
//   CNT_W  : width of the stall counter
//
// Ports
//   clk, rst (async, active-low), flush (synchronous)
//   ex_valid / ex_ready + ex_* bundle    : upstream handshake from EX
//   mem_valid / mem_ready + mem_* bundle : downstream handshake to MEM
//   stall_cnt : saturating count of edges with mem_valid & !mem_ready
// ---------------------------------------------------------------------------
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,

  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,

  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state;
  beat_t  in_beat;
  beat_t  main_q;
  beat_t  skid_q;
  logic   valid_q;
  logic   ready_q;
  logic   accept;
  logic   pop;

  assign in_beat = '{wdata: ex_wdata, wd: ex_wd, wreg: ex_wreg,
                     whilo: ex_whilo, hi: ex_hi, lo: ex_lo};

  assign accept = ex_valid & ex_ready;
  assign pop    = valid_q & mem_ready;

  // In skid mode ex_ready comes from a flop so the upstream timing path is
  // cut; flush is ORed in so a beat offered during a flush is swallowed.
  // In single-entry mode the stage can refill in the same cycle it drains.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign ex_ready = ready_q | flush;
    end else begin : g_ready_single
      assign ex_ready = ~valid_q | mem_ready | flush;
    end
  endgenerate

  // Occupancy FSM. Entries are zeroed whenever they empty so an idle stage
  // presents a NOP bundle to MEM. The skid entry only ever holds a beat
  // younger than main, so draining skid into main preserves FIFO order.
  // With SKID=0 the FULL+accept-without-pop case cannot arise because
  // ex_ready already requires mem_ready when main is occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q  <= in_beat;
            valid_q <= 1'b1;
            state   <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && pop) begin
            main_q <= in_beat;
          end else if (accept && (SKID != 0)) begin
            skid_q  <= in_beat;
            ready_q <= 1'b0;
            state   <= ST_SKID;
          end else if (pop) begin
            main_q  <= '0;
            valid_q <= 1'b0;
            state   <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (pop) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            ready_q <= 1'b1;
            state   <= ST_FULL;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Back-pressure counter: counts every edge where MEM refuses a presented
  // beat, sticks at all-ones and is only cleared by reset (flush keeps it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (valid_q && !mem_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign mem_valid = valid_q;
  assign mem_wdata = main_q.wdata;
  assign mem_wd    = main_q.wd;
  assign mem_wreg  = main_q.wreg;
  assign mem_whilo = main_q.whilo;
  assign mem_hi    = main_q.hi;
  assign mem_lo    = main_q.lo;

endmodule
